// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
//   - opcode constants for the supported instruction classes
//   - ALUOp / ALUControl codes
//   - mux select encodings for ResultSrc, ALUSrcA, ALUSrcB, ImmSrc
//   - FSM state enum
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP,
        S_FAULT
    } state_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder (combinational).
//   i_aluop     : 00 add, 01 sub, 10 decode funct3
//   i_funct3    : IR[14:12]
//   i_funct7b5  : IR[30]
//   i_opb5      : IR[5], distinguishes R-type (sub allowed) from I-type
//   o_aluctrl   : ALU operation code
module mc_alu_decoder
    import riscv_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [1:0]           i_aluop,
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7b5,
    input  logic                 i_opb5,
    output logic [ALUCTRL_W-1:0] o_aluctrl
);

    logic [2:0] w_code;

    always_comb begin
        w_code = ALU_ADD;
        unique case (i_aluop)
            ALUOP_ADD: w_code = ALU_ADD;
            ALUOP_SUB: w_code = ALU_SUB;
            ALUOP_FUNC: begin
                case (i_funct3)
                    // addi never subtracts: funct7[5] only means sub for R-type
                    3'b000:  w_code = (i_opb5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_code = ALU_SLT;
                    3'b110:  w_code = ALU_OR;
                    3'b111:  w_code = ALU_AND;
                    default: w_code = ALU_ADD;
                endcase
            end
            default: w_code = ALU_ADD;
        endcase
    end

    assign o_aluctrl = ALUCTRL_W'(w_code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing Fetch/Decode/
// Execute/Memory/Writeback over a shared-ALU, single-memory datapath.
//   clk, rst           : clock, synchronous active-low reset
//   Op/funct3/funct7   : instruction fields from IR
//   Zero               : ALU zero flag (branch decision)
//   MemReady           : memory completes the current access
//   MemReq..ImmSrc     : datapath enables and mux selects
//   ALUControl         : ALU operation
//   InstrDone          : retire pulse
//   Illegal / Fault    : sticky trap / memory-timeout indicators
module multicycle_control_unit
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter bit EN_JAL      = 1'b1,
    parameter int ALUCTRL_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 InstrDone,
    output logic                 Illegal,
    output logic                 Fault
);

    // Counter only needs to reach MEM_TIMEOUT-1
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    state_t           w_dec;
    logic [CNT_W-1:0] r_wait;
    logic             w_memreq_st;
    logic             w_timeout;
    logic [1:0]       w_aluop;
    logic             w_unused_f7;

    assign w_unused_f7 = ^{funct7[6], funct7[4:0]};

    // Memory-access states, independent of reset gating
    assign w_memreq_st = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);

    // MemReady in the last allowed cycle still wins over the timeout
    assign w_timeout = (MEM_TIMEOUT != 0) && w_memreq_st && !MemReady &&
                       (r_wait == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (MemReady)       w_next = S_DECODE;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_DECODE: begin
                case (Op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXEC_R;
                    OP_ITYPE:          w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:            w_next = EN_JAL ? S_JAL : S_TRAP;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (MemReady)       w_next = S_MEMWB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: begin
                if (MemReady)       w_next = S_FETCH;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_EXEC_R:   w_next = S_ALUWB;
            S_EXEC_I:   w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            S_FAULT:    w_next = S_FAULT;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (MEM_TIMEOUT != 0 && w_memreq_st && !MemReady)
                r_wait <= r_wait + CNT_W'(1);
        end
    end

    // During reset the selects show the FETCH encoding
    assign w_dec = rst ? r_state : S_FETCH;

    always_comb begin
        MemReq    = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        InstrDone = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        w_aluop   = ALUOP_ADD;
        case (w_dec)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq    = 1'b1;
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
            end
            S_EXEC_R: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                w_aluop = ALUOP_FUNC;
            end
            S_EXEC_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                w_aluop = ALUOP_FUNC;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                w_aluop   = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = Zero;
                InstrDone = 1'b1;
            end
            S_JAL: begin
                // PC <- target already in ALUOut; ALU forms OldPC+4 for rd
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
            end
            default: ;
        endcase
        if (!rst) begin
            MemReq    = 1'b0;
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            InstrDone = 1'b0;
        end
    end

    always_comb begin
        case (Op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    // Both are absorbing states, so state-derived flags stay set until reset
    assign Illegal = (r_state == S_TRAP);
    assign Fault   = (r_state == S_FAULT);

    mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .i_aluop    (w_aluop),
        .i_funct3   (funct3),
        .i_funct7b5 (funct7[5]),
        .i_opb5     (Op[5]),
        .o_aluctrl  (ALUControl)
    );

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised multi-cycle successor to the single-cycle RV32I control path. A Moore FSM sequences each instruction through Fetch/Decode/Execute/Memory/Writeback. It stalls on a memory ready handshake, times out on a hung memory, and traps on unsupported opcodes. It drives a shared-ALU, single-memory datapath: PC, OldPC, IR, Data and ALUOut registers.

Parameters:
MEM_TIMEOUT, 15, max wait cycles per memory access before FAULT; 0 disables the timeout.
EN_JAL, 1, 1 = decode jal (0x6F); 0 = jal traps as illegal.
ALUCTRL_W, 3, ALUControl width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-low reset.
Op  in  7  IR[6:0].
funct3  in  3  IR[14:12].
funct7  in  7  IR[31:25].
Zero  in  1  ALU zero flag.
MemReady  in  1  memory completes the current access this cycle.
MemReq  out  1  memory access request.
PCWrite  out  1  PC register enable.
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address.
IRWrite  out  1  IR and OldPC enable.
MemWrite  out  1  store strobe.
RegWrite  out  1  register file write.
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1.
ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
ALUControl  out  ALUCTRL_W  ALU operation.
InstrDone  out  1  one-cycle pulse when an instruction retires.
Illegal  out  1  sticky: unsupported opcode seen.
Fault  out  1  sticky: memory timeout.

Behaviour:
- Reset: rst=0 at a clock edge sets state=FETCH, clears the wait counter and clears Illegal and Fault.
- While rst=0, MemReq, PCWrite, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0. Selects show their FETCH encoding.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BEQ, JAL, TRAP, FAULT.
- FETCH: MemReq=1, AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite assert only in the cycle MemReady=1, which also moves to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: SrcA=01, SrcB=01, ALUOp=00 to form the branch target. Next state by Op:
  - 0x03 or 0x23 -> MEMADR
  - 0x33 -> EXEC_R
  - 0x13 -> EXEC_I
  - 0x63 -> BEQ
  - 0x6F -> JAL (if EN_JAL)
  - anything else -> TRAP
- MEMADR: SrcA=10, SrcB=01, ALUOp=00. Goes to MEMREAD for 0x03, MEMWRITE for 0x23.
- MEMREAD: MemReq=1, AdrSrc=1. Waits for MemReady, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1 -> FETCH.
- MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1 held until MemReady. On the ready cycle InstrDone=1 and -> FETCH.
- EXEC_R: SrcA=10, SrcB=00, ALUOp=10 -> ALUWB.
- EXEC_I: SrcA=10, SrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1 -> FETCH.
- BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00. PCWrite=Zero (the only Mealy term). InstrDone=1 -> FETCH.
- JAL: SrcA=01, SrcB=10, ResultSrc=00, PCWrite=1 -> ALUWB, which writes PC+4 to rd.
- ImmSrc is decoded from Op in all states: 0x23 -> 01, 0x63 -> 10, 0x6F -> 11, else 00.
- ALU decode:
  - ALUOp 00 -> add (000); 01 -> sub (001).
  - ALUOp 10 decodes funct3: 000 -> sub if Op[5] & funct7[5], else add; 010 -> slt (101); 110 -> or (011); 111 -> and (010).
  - Any other funct3 -> add; this is not illegal.
- Wait counter: increments each cycle MemReq=1 and MemReady=0, and clears on any state change.
  - If the counter reaches MEM_TIMEOUT-1 with MemReady still 0, the next state is FAULT.
  - MemReady=1 in the same cycle wins: the access completes normally.
- TRAP and FAULT: absorbing states. All enables are 0 and Illegal (resp. Fault) stays 1. Only reset exits.
- Throughput: load 5 cycles, store 4, R/I-type 4, branch 3, jal 4, plus memory wait cycles.

Decomposition:
- Shared package riscv_pkg: opcode constants, ALUOp codes, ALUControl codes, ResultSrc/SrcA/SrcB/ImmSrc encodings, state enum.
- Sub-module mc_alu_decoder: combinational; ALUOp, funct3, funct7[5], Op[5] -> ALUControl.

Test Plan:
- Reset, then add x3,x1,x2 with MemReady always 1 -> states FETCH, DECODE, EXEC_R, ALUWB. ALUControl=000; RegWrite and InstrDone pulse in cycle 4.
- lw with MemReady low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with AdrSrc=1. RegWrite with ResultSrc=01 follows; no Fault.
- beq with Zero=1, then with Zero=0 -> PCWrite=1 in BEQ only when Zero=1; ALUControl=001 both times.
- Op=0x37 (lui) -> TRAP after DECODE; Illegal=1 and all enables 0 for 20 cycles; rst=0 clears it and FETCH resumes.
- MEM_TIMEOUT=15, MemReady stuck 0 in FETCH -> FAULT entered after 15 cycles. Repeat with MemReady=1 on the 15th cycle -> DECODE reached, no Fault.
- rst=0 asserted mid-MEMWRITE -> MemWrite drops the same cycle; state is FETCH after the edge.
